// File: rtl/jk_pkg.sv
// Shared JK encodings and the single-bit next-state function.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Next state of one JK flip-flop given its current state and {j, k}.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        unique case ({j, k})
            JK_HOLD:   nxt = q;
            JK_RESET:  nxt = 1'b0;
            JK_SET:    nxt = 1'b1;
            JK_TOGGLE: nxt = ~q;
            default:   nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK channel: state flop, change pulse flop and saturating change counter.
module jk_cell
    import jk_pkg::*;
#(
    parameter int unsigned CNT_W   = 4,
    parameter logic        RST_BIT = 1'b0
) (
    input  logic             en_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             load_i,
    input  logic             d_i,
    input  logic             j_i,
    input  logic             k_i,
    input  logic             cnt_clr_i,
    output logic             q_o,
    output logic             changed_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             q_d, q_q;
    logic             changed_d, changed_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             jk_chg;

    // Next state: load beats JK; only JK-driven changes feed the counter.
    always_comb begin
        q_d    = q_q;
        jk_chg = 1'b0;
        if (load_i) begin
            q_d = d_i;
        end else if (ce_i) begin
            q_d    = jk_next(q_q, j_i, k_i);
            jk_chg = (q_d != q_q);
        end
        changed_d = (q_d != q_q);
        cnt_d     = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (jk_chg && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge en_i) begin
        if (rst_i) begin
            q_q       <= RST_BIT;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign q_o       = q_q;
    assign changed_o = changed_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH independent JK channels with load, change pulses and change counters.
module jk_register_bank
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   en_i,
    input  logic                   rst_i,
    input  logic                   ce_i,
    input  logic                   load_i,
    input  logic [WIDTH-1:0]       d_i,
    input  logic [WIDTH-1:0]       j_i,
    input  logic [WIDTH-1:0]       k_i,
    input  logic                   cnt_clr_i,
    output logic [WIDTH-1:0]       q_o,
    output logic [WIDTH-1:0]       q_bar_o,
    output logic [WIDTH-1:0]       changed_o,
    output logic [WIDTH*CNT_W-1:0] toggle_cnt_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell #(
            .CNT_W   (CNT_W),
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .en_i      (en_i),
            .rst_i     (rst_i),
            .ce_i      (ce_i),
            .load_i    (load_i),
            .d_i       (d_i[i]),
            .j_i       (j_i[i]),
            .k_i       (k_i[i]),
            .cnt_clr_i (cnt_clr_i),
            .q_o       (q_o[i]),
            .changed_o (changed_o[i]),
            .cnt_o     (toggle_cnt_o[i*CNT_W +: CNT_W])
        );
    end

    assign q_bar_o = ~q_o;

endmodule

// File: tb/tb_jk_register_bank.sv
// Scoreboard bench: stimulus pushes expected post-edge state, monitor pops and compares.
module tb_jk_register_bank;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam logic [7:0]  RV    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst, ce, load, cnt_clr;
    logic [7:0]  d, j, k;
    logic [7:0]  q, q_bar, changed;
    logic [31:0] toggle_cnt;

    typedef struct packed {
        logic [7:0]  q;
        logic [7:0]  qb;
        logic [7:0]  chg;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state
    logic [7:0]  mq;
    int unsigned mcnt[8];

    always #5 clk = ~clk;

    jk_register_bank #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .RESET_VAL (RV)
    ) dut (
        .en_i         (clk),
        .rst_i        (rst),
        .ce_i         (ce),
        .load_i       (load),
        .d_i          (d),
        .j_i          (j),
        .k_i          (k),
        .cnt_clr_i    (cnt_clr),
        .q_o          (q),
        .q_bar_o      (q_bar),
        .changed_o    (changed),
        .toggle_cnt_o (toggle_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic step(input logic r, input logic ld, input logic c, input logic clr,
                        input logic [7:0] dv, input logic [7:0] jv, input logic [7:0] kv);
        logic [7:0] nq, chg;
        exp_t       e;
        @(negedge clk);
        rst = r; load = ld; ce = c; cnt_clr = clr; d = dv; j = jv; k = kv;
        if (r) begin
            nq  = RV;
            chg = 8'h00;
            for (int i = 0; i < 8; i++) mcnt[i] = 0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (ld)     nq[i] = dv[i];
                else if (c) begin
                    case ({jv[i], kv[i]})
                        2'b00:   nq[i] = mq[i];
                        2'b01:   nq[i] = 1'b0;
                        2'b10:   nq[i] = 1'b1;
                        default: nq[i] = ~mq[i];
                    endcase
                end else    nq[i] = mq[i];
            end
            chg = nq ^ mq;
            for (int i = 0; i < 8; i++) begin
                if (clr)                                 mcnt[i] = 0;
                else if (c && !ld && chg[i] && mcnt[i] < 15) mcnt[i] = mcnt[i] + 1;
            end
        end
        mq    = nq;
        e.q   = nq;
        e.qb  = ~nq;
        e.chg = chg;
        for (int i = 0; i < 8; i++) e.cnt[i*4 +: 4] = mcnt[i][3:0];
        sb_q.push_back(e);
    endtask

    // Monitor: every edge presents a new output; compare against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("q", {24'h0, q}, {24'h0, e.q});
            check("q_bar", {24'h0, q_bar}, {24'h0, e.qb});
            check("changed", {24'h0, changed}, {24'h0, e.chg});
            check("toggle_cnt", toggle_cnt, e.cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = 1'b0; ce = 1'b0; cnt_clr = 1'b0; d = '0; j = '0; k = '0;
        mq = RV;
        for (int i = 0; i < 8; i++) mcnt[i] = 0;

        // Reset for two edges: q=A5, q_bar=5A, changed=0, counters=0
        step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);

        // Toggle all channels for 20 edges; counters saturate at 15
        for (int n = 0; n < 20; n++) step(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);

        // Clear counters while holding, then j=0F k=F0 from A5 -> 0F, changed=AA
        step(0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h0F, 8'hF0);

        // Load beats JK: q=3C, changed=33, counters unchanged
        step(0, 1, 1, 0, 8'h3C, 8'hFF, 8'hFF);

        // ce=0 with arbitrary j/k: hold, changed=0
        step(0, 0, 0, 0, 8'h00, 8'h5A, 8'hC3);
        step(0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, 8'h00, 8'h0F, 8'h00);
        step(0, 0, 0, 0, 8'h00, 8'h00, 8'hF0);
        step(0, 0, 0, 0, 8'h00, 8'h96, 8'h69);

        // Build counts, then cnt_clr together with a toggle: counter 0, changed 1
        step(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);
        step(0, 0, 1, 0, 8'h00, 8'hFF, 8'hFF);
        step(0, 0, 1, 1, 8'h00, 8'hFF, 8'hFF);
        step(0, 0, 1, 0, 8'h00, 8'h81, 8'h18);

        // Reset wins over load, ce and cnt_clr
        step(1, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF);
        // Normal JK on the next edge: set all from A5 -> FF, changed=5A
        step(0, 0, 1, 0, 8'h00, 8'hFF, 8'h00);
        step(0, 0, 1, 0, 8'h00, 8'h00, 8'hFF);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_register_bank.md
# jk_register_bank

Parametrised bank of WIDTH independent JK flip-flop channels sharing one clock, with a clock enable, synchronous parallel load, a one-cycle change indicator per channel and a saturating per-channel change counter. It generalises the single-bit behavioural JK flip-flop into a multi-channel register used in control and status logic. It also provides change observability for debug and event counting.

## Interface
- WIDTH, 8: number of JK channels, at least 1
- CNT_W, 4: width of each per-channel change counter, at least 1
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset
- en  in  1  clock, rising-edge active (the codebase's clock port name)
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable for JK evaluation; 0 = all channels hold
- load  in  1  synchronous parallel load of d into q
- d  in  WIDTH  parallel load data
- j  in  WIDTH  per-channel J inputs
- k  in  WIDTH  per-channel K inputs
- cnt_clr  in  1  synchronous clear of all change counters
- q  out  WIDTH  registered state
- q_bar  out  WIDTH  always equal to ~q, no extra latency
- changed  out  WIDTH  bit i = 1 for the cycle after q[i] changed value
- toggle_cnt  out  WIDTH*CNT_W  channel i counter in bits [i*CNT_W +: CNT_W]

## Operation
- Per-channel next-state priority, evaluated at each rising edge of en:
  - rst: q = RESET_VAL.
  - Otherwise load: q = d. Ignores ce, j and k.
  - Otherwise ce = 1: JK rule per bit. 00 holds, 01 clears to 0, 10 sets to 1, 11 toggles.
  - Otherwise (ce = 0): hold.
- changed[i] is registered as (q_next[i] != q[i]).
  - It covers JK changes and load changes.
  - It is 0 on the cycle after reset.
- toggle_cnt channel i counts JK-driven changes only: the ce path with q_next[i] != q[i].
  - A load-driven change does not count.
  - The counter saturates at 2^CNT_W - 1 and does not wrap.
- Counter priority: rst, then cnt_clr, then increment.
  - cnt_clr in the same cycle as a counted change gives 0.
  - In that case changed[i] is still 1.
- Channels are fully independent except for the shared rst, ce, load and cnt_clr.

## Timing
- Reset values: q = RESET_VAL, q_bar = ~RESET_VAL, changed = 0, toggle_cnt = 0.
- All of these take effect at the first rising edge with rst = 1.
- Latency: q, changed and toggle_cnt update at the same rising edge, which is 1 cycle after the inputs are sampled.
- q_bar follows q combinationally.
- changed is a single-cycle pulse per change event. A channel toggling every cycle holds changed[i] = 1 continuously.
- rst asserted mid-operation wins over load, ce and cnt_clr in that cycle. Normal operation resumes on the first edge with rst = 0.
- Inputs are sampled only at rising edges; input glitches between edges have no effect.

## Structure
- Shared package jk_pkg holds:
  - JK code constants JK_HOLD = 2'b00, JK_RESET = 2'b01, JK_SET = 2'b10, JK_TOGGLE = 2'b11
  - a function jk_next(q, j, k) returning the next state
- Sub-module jk_cell implements one channel: q flop, changed flop and a CNT_W-bit saturating counter.
- It has parameters CNT_W and RST_BIT.
- jk_register_bank contains a generate loop of WIDTH jk_cell instances plus the q_bar inversion.

## Test plan
- WIDTH=8, CNT_W=4, RESET_VAL=8'hA5. Hold rst for 2 edges, then check:
  - q = 8'hA5, q_bar = 8'h5A, changed = 0, all counters = 0.
- ce = 1, j = 8'hFF, k = 8'hFF for 20 edges. Expect:
  - q alternating 8'h5A / 8'hA5
  - changed = 8'hFF from the cycle after the first edge
  - every counter saturating at 15 and staying at 15
- ce = 1, j = 8'h0F, k = 8'hF0, from q = 8'hA5. Expect:
  - q = 8'h0F after 1 edge
  - changed = 8'hAA (bits that differed)
  - only those channels' counters increment
- load = 1, d = 8'h3C, ce = 1, j = k = 8'hFF. Expect:
  - q = 8'h3C; load beats JK
  - changed reflects the differences
  - counters unchanged
- ce = 0 with arbitrary j/k for 5 edges: q holds, changed = 0. Then cnt_clr plus a toggle in the same cycle: counter = 0, changed = 1.
- rst asserted alongside load = 1, d = 8'hFF, cnt_clr = 1 mid-run. Expect:
  - q = RESET_VAL and counters = 0 at that edge
  - normal JK operation on the next edge after rst deasserts
